// File: rtl/domain_mux_arb.sv
// ---------------------------------------------------------------------------
// domain_mux_arb
//
// Purpose:
//   Two-requester val/rdy arbiter feeding a one-entry registered output.
//   Each request carries a 2-bit security domain tag. Contention is resolved
//   by a round-robin priority pointer. Optionally, every change of domain on
//   the output is preceded by a one-cycle scrub. The scrub clears the output
//   message so no data from the previous domain lingers on out_msg.
//
// Configuration:
//   DOMAIN_MUX_ARB_SCRUB_EN
//     - Defined: domain changes insert a scrub cycle. The winner is then
//       locked until it is accepted.
//     - Undefined: domain changes pass back-to-back. last_domain is still
//       tracked.
//
// Parameters:
//   p_nbits       message width
//
// Ports:
//   clk           single clock; all state updates on its rising edge
//   reset_n       asynchronous active-low reset
//   req0_val      requester 0 valid
//   req0_rdy      requester 0 ready
//   req0_msg      requester 0 message
//   req0_domain   requester 0 domain tag
//   req1_*        same four signals for requester 1
//   out_val       registered output valid
//   out_rdy       output ready from the consumer
//   out_msg       registered output message
//   out_domain    registered output domain tag
//   sel           2:1 mux select (0 = requester 0, 1 = requester 1)
// ---------------------------------------------------------------------------
module domain_mux_arb #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset_n,

  input  logic               req0_val,
  output logic               req0_rdy,
  input  logic [p_nbits-1:0] req0_msg,
  input  logic [1:0]         req0_domain,

  input  logic               req1_val,
  output logic               req1_rdy,
  input  logic [p_nbits-1:0] req1_msg,
  input  logic [1:0]         req1_domain,

  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic [1:0]         out_domain,

  output logic               sel
);

`ifdef DOMAIN_MUX_ARB_SCRUB_EN
  localparam bit scrub_en = 1'b1;
`else
  localparam bit scrub_en = 1'b0;
`endif

  typedef enum logic {
    RUN   = 1'b0,
    SCRUB = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [1:0]           last_domain;
  logic                 ptr;
  logic                 lock;
  logic                 lock_sel;
  logic [1:0]           lock_domain;
  logic                 sel_q;

  logic                 winner;
  logic                 win_val;
  logic [p_nbits-1:0]   win_msg;
  logic [1:0]           win_domain;
  logic                 can_accept;
  logic                 scrub_required;
  logic                 accept;

  // Arbitration and handshake.
  // While a lock is held only the locked requester may win. This holds even
  // if it has dropped val, so a scrubbed domain is never handed to the other
  // requester. Outside a lock:
  //   - a lone valid request wins;
  //   - a tie goes to ptr.
  // scrub_en is a constant, so the scrub path vanishes when it is disabled.
  always_comb begin
    winner         = ptr;
    win_val        = 1'b0;
    win_msg        = req0_msg;
    win_domain     = req0_domain;
    can_accept     = 1'b0;
    scrub_required = 1'b0;
    accept         = 1'b0;
    req0_rdy       = 1'b0;
    req1_rdy       = 1'b0;
    sel            = sel_q;
    state_next     = state;

    if (lock) begin
      winner = lock_sel;
    end else if (req0_val && !req1_val) begin
      winner = 1'b0;
    end else if (req1_val && !req0_val) begin
      winner = 1'b1;
    end else begin
      winner = ptr;
    end

    win_val    = winner ? req1_val    : req0_val;
    win_msg    = winner ? req1_msg    : req0_msg;
    win_domain = winner ? req1_domain : req0_domain;

    can_accept     = (state == RUN) && (!out_val || out_rdy);
    scrub_required = scrub_en && can_accept && win_val &&
                     (win_domain != last_domain);
    accept         = can_accept && win_val && !scrub_required;

    req0_rdy = accept && !winner;
    req1_rdy = accept &&  winner;

    if (win_val) begin
      sel = winner;
    end

    case (state)
      RUN:     if (scrub_required) state_next = SCRUB;
      SCRUB:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Output register, domain tracking, priority pointer and lock.
  // Starting a scrub latches the winner and its domain. The scrub cycle
  // itself then blanks the output to that domain. Any output already present
  // when the scrub starts has been consumed, because can_accept required
  // out_rdy. ptr only moves on a real accept, so a scrub leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_val     <= 1'b0;
      out_msg     <= '0;
      out_domain  <= 2'd0;
      last_domain <= 2'd0;
      ptr         <= 1'b0;
      lock        <= 1'b0;
      lock_sel    <= 1'b0;
      lock_domain <= 2'd0;
      sel_q       <= 1'b0;
    end else begin
      if (state == SCRUB) begin
        out_val     <= 1'b0;
        out_msg     <= '0;
        out_domain  <= lock_domain;
        last_domain <= lock_domain;
      end else if (scrub_required) begin
        lock        <= 1'b1;
        lock_sel    <= winner;
        lock_domain <= win_domain;
        out_val     <= 1'b0;
      end else if (accept) begin
        out_val     <= 1'b1;
        out_msg     <= win_msg;
        out_domain  <= win_domain;
        last_domain <= win_domain;
        ptr         <= ~winner;
        lock        <= 1'b0;
      end else if (out_val && out_rdy) begin
        out_val     <= 1'b0;
      end

      if (win_val) begin
        sel_q <= winner;
      end
    end
  end

endmodule

// File: tb/tb_domain_mux_arb.sv
// ---------------------------------------------------------------------------
// tb_domain_mux_arb
//
// Purpose:
//   Self-checking directed bench for domain_mux_arb. The bench follows the
//   DOMAIN_MUX_ARB_SCRUB_EN macro, so the same file suits both builds.
// ---------------------------------------------------------------------------
module tb_domain_mux_arb;

  logic        clk;
  logic        reset_n;
  logic        req0_val;
  logic        req0_rdy;
  logic [31:0] req0_msg;
  logic [1:0]  req0_domain;
  logic        req1_val;
  logic        req1_rdy;
  logic [31:0] req1_msg;
  logic [1:0]  req1_domain;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_msg;
  logic [1:0]  out_domain;
  logic        sel;

  int err_count;
  int check_count;

  domain_mux_arb #(.p_nbits(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req0_val    (req0_val),
    .req0_rdy    (req0_rdy),
    .req0_msg    (req0_msg),
    .req0_domain (req0_domain),
    .req1_val    (req1_val),
    .req1_rdy    (req1_rdy),
    .req1_msg    (req1_msg),
    .req1_domain (req1_domain),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .out_msg     (out_msg),
    .out_domain  (out_domain),
    .sel         (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check_output(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive both requesters and the output ready in one call.
  task automatic apply_stimulus(input logic v0, input logic [31:0] m0,
                                input logic [1:0] d0, input logic v1,
                                input logic [31:0] m1, input logic [1:0] d1,
                                input logic ordy);
    req0_val    = v0;
    req0_msg    = m0;
    req0_domain = d0;
    req1_val    = v1;
    req1_msg    = m1;
    req1_domain = d1;
    out_rdy     = ordy;
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset, then release it away from the rising edge.
  task automatic do_reset();
    apply_stimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b1);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    err_count   = 0;
    check_count = 0;
    reset_n     = 1'b1;
    apply_stimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b1);

    // Reset state
    #2;
    reset_n = 1'b0;
    #1;
    check_output("rst_out_val", 32'(out_val), 32'h0);
    check_output("rst_out_msg", out_msg, 32'h0);
    check_output("rst_out_domain", 32'(out_domain), 32'h0);
    check_output("rst_sel", 32'(sel), 32'h0);
    check_output("rst_rdy0", 32'(req0_rdy), 32'h0);
    do_reset();

    // Single request: accepted on the first edge after release
    apply_stimulus(1'b1, 32'hA5, 2'd0, 1'b0, 32'h0, 2'd0, 1'b1);
    #1;
    check_output("single_rdy0", 32'(req0_rdy), 32'h1);
    check_output("single_rdy1", 32'(req1_rdy), 32'h0);
    check_output("single_sel", 32'(sel), 32'h0);
    tick();
    check_output("single_out_val", 32'(out_val), 32'h1);
    check_output("single_out_msg", out_msg, 32'hA5);
    check_output("single_out_domain", 32'(out_domain), 32'h0);
    req0_val = 1'b0;
    #1;
    check_output("single_sel_hold", 32'(sel), 32'h0);

    // Both valid in domain 0: grants alternate 0,1,0,1
    do_reset();
    apply_stimulus(1'b1, 32'h11, 2'd0, 1'b1, 32'h22, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_output($sformatf("rr_sel_%0d", i), 32'(sel), 32'(i % 2));
      check_output($sformatf("rr_rdy0_%0d", i), 32'(req0_rdy),
                   32'(i % 2 == 0));
      tick();
      check_output($sformatf("rr_out_val_%0d", i), 32'(out_val), 32'h1);
      check_output($sformatf("rr_out_msg_%0d", i), out_msg,
                   (i % 2 == 0) ? 32'h11 : 32'h22);
    end

    // Output full and stalled: no accept until out_rdy rises
    apply_stimulus(1'b1, 32'h55, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check_output($sformatf("stall_rdy0_%0d", i), 32'(req0_rdy), 32'h0);
      tick();
      check_output($sformatf("stall_msg_%0d", i), out_msg, 32'h22);
      check_output($sformatf("stall_val_%0d", i), 32'(out_val), 32'h1);
    end
    out_rdy = 1'b1;
    #1;
    check_output("drain_rdy0", 32'(req0_rdy), 32'h1);
    tick();
    check_output("drain_out_msg", out_msg, 32'h55);
    check_output("drain_out_val", 32'(out_val), 32'h1);
    req0_val = 1'b0;
    tick();
    check_output("empty_out_val", 32'(out_val), 32'h0);
    check_output("empty_out_msg", out_msg, 32'h55);

    // Reset with a full, stalled output discards it
    do_reset();
    apply_stimulus(1'b1, 32'h99, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0);
    tick();
    check_output("full_out_val", 32'(out_val), 32'h1);
    req0_val = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_output("full_rst_val", 32'(out_val), 32'h0);
    check_output("full_rst_msg", out_msg, 32'h0);
    do_reset();

`ifdef DOMAIN_MUX_ARB_SCRUB_EN
    // Domain 0 transfer, then requester 1 in domain 2 forces a scrub
    apply_stimulus(1'b1, 32'hA5, 2'd0, 1'b0, 32'h0, 2'd0, 1'b1);
    tick();
    check_output("scrub_pre_msg", out_msg, 32'hA5);
    apply_stimulus(1'b0, 32'h0, 2'd0, 1'b1, 32'h3C, 2'd2, 1'b1);
    #1;
    check_output("scrub_start_rdy1", 32'(req1_rdy), 32'h0);
    tick();
    check_output("scrub_cycle_val", 32'(out_val), 32'h0);
    check_output("scrub_cycle_rdy1", 32'(req1_rdy), 32'h0);
    tick();
    check_output("scrub_blank_val", 32'(out_val), 32'h0);
    check_output("scrub_blank_msg", out_msg, 32'h0);
    check_output("scrub_blank_domain", 32'(out_domain), 32'h2);
    check_output("scrub_lock_rdy1", 32'(req1_rdy), 32'h1);
    tick();
    check_output("scrub_post_val", 32'(out_val), 32'h1);
    check_output("scrub_post_msg", out_msg, 32'h3C);
    check_output("scrub_post_domain", 32'(out_domain), 32'h2);

    // Reset during a scrub clears everything; next domain-0 request is clean
    apply_stimulus(1'b1, 32'h66, 2'd0, 1'b0, 32'h0, 2'd0, 1'b1);
    #1;
    check_output("midscrub_rdy0", 32'(req0_rdy), 32'h0);
    tick();
    req0_val = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_output("midscrub_rst_val", 32'(out_val), 32'h0);
    check_output("midscrub_rst_msg", out_msg, 32'h0);
    check_output("midscrub_rst_domain", 32'(out_domain), 32'h0);
    check_output("midscrub_rst_sel", 32'(sel), 32'h0);
    do_reset();
`else
    // Alternating domains 0 and 3 stream with no bubbles
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 32'h40 + 32'(i), (i % 2 == 0) ? 2'd0 : 2'd3,
                     1'b0, 32'h0, 2'd0, 1'b1);
      #1;
      check_output($sformatf("stream_rdy0_%0d", i), 32'(req0_rdy), 32'h1);
      tick();
      check_output($sformatf("stream_val_%0d", i), 32'(out_val), 32'h1);
      check_output($sformatf("stream_msg_%0d", i), out_msg, 32'h40 + 32'(i));
      check_output($sformatf("stream_dom_%0d", i), 32'(out_domain),
                   (i % 2 == 0) ? 32'h0 : 32'h3);
    end
    do_reset();
`endif

    // First request after release is accepted in domain 0 without a scrub
    apply_stimulus(1'b1, 32'h77, 2'd0, 1'b0, 32'h0, 2'd0, 1'b1);
    #1;
    check_output("post_rst_rdy0", 32'(req0_rdy), 32'h1);
    tick();
    check_output("post_rst_val", 32'(out_val), 32'h1);
    check_output("post_rst_msg", out_msg, 32'h77);
    check_output("post_rst_domain", 32'(out_domain), 32'h0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule

// File: doc/domain_mux_arb.md
DOMAIN_MUX_ARB -- requirements
Module: domain_mux_arb

Interface
REQ-001 The block SHALL have parameter p_nbits, default 32, setting the message width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_val (input, 1), req0_rdy (output, 1), req0_msg (input, p_nbits) and req0_domain (input, 2), forming requester 0's val/rdy channel and its security domain tag.
REQ-005 The block SHALL have ports req1_val, req1_rdy, req1_msg and req1_domain, identical in direction and width to requester 0's.
REQ-006 The block SHALL have ports out_val (output, 1), out_rdy (input, 1), out_msg (output, p_nbits) and out_domain (output, 2), forming the registered output channel and its domain tag.
REQ-007 The block SHALL have port sel, output, 1 bit, the 2:1 mux select: 0 for requester 0, 1 for requester 1; it is valid when a grant occurs.

Function
REQ-008 A transfer SHALL occur on reqN when reqN_val and reqN_rdy are both high at a clock edge; a requester holds val, msg and domain stable until it is accepted.
REQ-009 The output SHALL be a one-entry register; can_accept = state RUN and (out_val low or out_rdy high).
REQ-010 The winner SHALL be chosen as follows: only one val high, that requester wins; both high, the requester named by priority pointer ptr wins.
REQ-011 If the lock flag is set, the winner SHALL be the locked requester regardless of ptr.
REQ-012 At most one reqN_rdy SHALL be high in any cycle, and it SHALL be high only for the winner when can_accept holds and no scrub is required.
REQ-013 On an accept, the block SHALL load out_msg and out_domain from the winner, set out_val, set last_domain to the winner's domain, set ptr to the non-winner, and clear lock.
REQ-014 sel SHALL equal the winner index combinationally; when no request is valid, sel SHALL hold its last registered value.
REQ-015 If out_val and out_rdy are high and no accept occurs, out_val SHALL clear next cycle and out_msg and out_domain SHALL hold.
REQ-016 Latency SHALL be one cycle from request accept to out_val high, with full throughput of one transfer per cycle when domains match.
REQ-017 The FSM SHALL have states RUN and SCRUB; scrub_required = can_accept and winner domain != last_domain.
REQ-018 On scrub_required, the block SHALL hold both rdy low, record the winner in lock_sel, set lock, and enter SCRUB.
REQ-019 In SCRUB (exactly one cycle), the block SHALL keep out_val low, write out_msg to 0 and out_domain to the locked domain, set last_domain to the locked domain, and then return to RUN.
REQ-020 Because lock is set, the first accept after SCRUB SHALL go to lock_sel; ptr SHALL be unchanged by a scrub.
REQ-021 If out_val is high and out_rdy is low when scrub_required would arise, can_accept SHALL be false and no scrub SHALL start until the output drains.
REQ-022 If valid requests disappear during SCRUB, the block SHALL not error; lock SHALL persist until the locked requester is accepted.

Reset
REQ-023 Reset assertion SHALL asynchronously force out_val=0, out_msg=0, out_domain=0, last_domain=0, ptr=0, lock=0, lock_sel=0, state=RUN and the sel register=0.
REQ-024 Reset mid-SCRUB or with a full output SHALL discard the pending data and lock, with no transfer completing.
REQ-025 After deassertion, the first accept SHALL be possible on the first rising edge with reset_n high.

Configuration
REQ-026 Macro DOMAIN_MUX_ARB_SCRUB_EN SHALL control the scrub feature: when defined, REQ-017 to REQ-022 apply.
REQ-027 When DOMAIN_MUX_ARB_SCRUB_EN is undefined, scrub_required SHALL be constant 0, SCRUB SHALL be unreachable and the lock flag SHALL never set; domain changes SHALL pass back-to-back, with last_domain still tracked.

Verification
REQ-028 The bench SHALL cover: reset, then req0 domain 0, msg 0xA5 with out_rdy=1 -> req0_rdy=1 in cycle 0, then out_val=1, out_msg=0xA5, out_domain=0, sel=0 in cycle 1.
REQ-029 The bench SHALL cover: both requesters valid in domain 0 continuously with out_rdy=1 -> grants alternate 0,1,0,1, starting with 0.
REQ-030 The bench SHALL cover: with SCRUB_EN, a domain 0 transfer followed by req1 domain 2, msg 0x3C -> one cycle with out_val=0 and out_msg=0, then out_msg=0x3C and out_domain=2.
REQ-031 The bench SHALL cover: out_rdy=0 with output full and req0 valid -> req0_rdy stays 0; when out_rdy rises, an accept occurs in the same cycle and the new data appears next cycle.
REQ-032 The bench SHALL cover: reset_n asserted during SCRUB -> all outputs 0 immediately, and the first request after release is accepted in domain 0 without a scrub.
REQ-033 The bench SHALL cover: without SCRUB_EN, alternating domains 0 and 3 with out_rdy=1 -> one transfer per cycle and no bubbles.
